// File: rtl/bus_pkg.sv
// Shared definitions for the bus scheduler: slot encodings, bus owner
// enumeration and the ROM address decode constant.
package bus_pkg;

    // Slot numbering inside one four-clock CPU cycle
    localparam logic [1:0] SLOT_FETCH_LO = 2'd0;
    localparam logic [1:0] SLOT_FETCH_HI = 2'd1;
    localparam logic [1:0] SLOT_CPU_A    = 2'd2;
    localparam logic [1:0] SLOT_CPU_B    = 2'd3;

    // Address bits 15:14 that select the ROM
    localparam logic [1:0] ROM_DECODE = 2'b11;

    // Width of the per-scanline DMA grant counter
    localparam int LINE_CNT_W = 6;

    // Owner of the video-fetch slot pair
    typedef enum logic {
        VIDEO = 1'b0,
        DMA   = 1'b1
    } owner_e;

    // True for the two fetch slots, false for the two CPU slots
    function automatic logic is_fetch_slot(input logic [1:0] slot);
        return (slot[1] == 1'b0);
    endfunction

endpackage

// File: rtl/bus_slot_counter.sv
// Four-phase slot counter. Produces the slot number being set up this clock
// and the registered CPU clock (phi2) and final-quarter flag (last) that
// describe the slot presented on the outputs after the next edge.
module bus_slot_counter
    import bus_pkg::*;
(
    input  logic       master_clock,
    input  logic       reset_n,
    output logic [1:0] slot,
    output logic       phi2,
    output logic       last
);

    logic [1:0] slot_r;
    logic       phi2_r;
    logic       last_r;

    // Free-running slot counter; outputs follow the slot being loaded
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            slot_r <= SLOT_FETCH_LO;
            phi2_r <= 1'b0;
            last_r <= 1'b0;
        end else begin
            slot_r <= slot_r + 2'd1;
            phi2_r <= slot_r[1];
            last_r <= (slot_r == SLOT_CPU_B);
        end
    end

    assign slot = slot_r;
    assign phi2 = phi2_r;
    assign last = last_r;

endmodule

// File: rtl/bus_scheduler.sv
// Bus scheduler: time-slices the shared memory bus between video fetch,
// an optional DMA requester and the CPU, and generates the active-low
// memory/VIA strobes. All outputs are registered and describe the slot
// that the slot counter held at the preceding edge, so the first clock
// after reset release is slot 0.
// Optional feature: define DMA_PORT_EN to enable the DMA owner, the
// per-line grant counter and the dma_grant/dma_ack handshake.
module bus_scheduler
    import bus_pkg::*;
#(
    parameter logic [7:0] VIA_PAGE     = 8'h07,
    parameter int         DMA_LINE_MAX = 16
)
(
    input  logic       master_clock,
    input  logic       reset_n,
    input  logic [7:0] cpu_addr_hi,
    input  logic       cpu_rw,
    input  logic       blank,
    input  logic       line_start,
    input  logic       dma_req,
    input  logic       dma_rw,
    output logic       phi2,
    output logic       last,
    output logic       latch,
    output logic       ram,
    output logic       rom,
    output logic       via,
    output logic       oe,
    output logic       we,
    output logic       vid_en,
    output logic       dma_grant,
    output logic       dma_ack
);

    localparam logic [LINE_CNT_W-1:0] LINE_MAX_C = LINE_CNT_W'(DMA_LINE_MAX);

    logic [1:0] slot_s;
    owner_e     owner_r;
    owner_e     owner_next_s;

    logic latch_s, ram_s, rom_s, via_s, oe_s, we_s, vid_en_s, grant_s, ack_s;
    logic latch_r, ram_r, rom_r, via_r, oe_r, we_r, vid_en_r, grant_r, ack_r;

    bus_slot_counter u_slot (
        .master_clock (master_clock),
        .reset_n      (reset_n),
        .slot         (slot_s),
        .phi2         (phi2),
        .last         (last)
    );

`ifdef DMA_PORT_EN
    logic [LINE_CNT_W-1:0] line_cnt_r;

    // Per-line DMA grant counter; a coincident line start counts that grant
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            line_cnt_r <= {LINE_CNT_W{1'b0}};
        end else if (line_start && ack_r) begin
            line_cnt_r <= {{(LINE_CNT_W-1){1'b0}}, 1'b1};
        end else if (line_start) begin
            line_cnt_r <= {LINE_CNT_W{1'b0}};
        end else if (ack_r && (line_cnt_r < LINE_MAX_C)) begin
            line_cnt_r <= line_cnt_r + {{(LINE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            line_cnt_r <= line_cnt_r;
        end
    end
`else
    // Without the DMA port these inputs have no effect on the bus
    logic dma_port_unused_s;
    assign dma_port_unused_s = dma_req ^ dma_rw ^ blank ^ line_start ^ (|LINE_MAX_C);
`endif

    // Owner next-state: decided only as the slot counter wraps 3 -> 0
    always_comb begin
        owner_next_s = owner_r;
        if (slot_s == SLOT_CPU_B) begin
`ifdef DMA_PORT_EN
            if (dma_req && blank && (line_cnt_r < LINE_MAX_C)) begin
                owner_next_s = DMA;
            end else begin
                owner_next_s = VIDEO;
            end
`else
            owner_next_s = VIDEO;
`endif
        end else begin
            owner_next_s = owner_r;
        end
    end

    // Owner state register
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            owner_r <= VIDEO;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    // Strobe and bus-enable decode for the slot being loaded
    always_comb begin
        latch_s  = 1'b1;
        ram_s    = 1'b1;
        rom_s    = 1'b1;
        via_s    = 1'b1;
        oe_s     = 1'b1;
        we_s     = 1'b1;
        vid_en_s = 1'b0;
        grant_s  = 1'b0;
        ack_s    = 1'b0;
        case (slot_s)
            SLOT_FETCH_LO, SLOT_FETCH_HI: begin
                ram_s = 1'b0;
                if (owner_r == VIDEO) begin
                    vid_en_s = 1'b1;
                    oe_s     = 1'b0;
                    latch_s  = (slot_s != SLOT_FETCH_LO);
                end else begin
`ifdef DMA_PORT_EN
                    grant_s = 1'b1;
                    ack_s   = (slot_s == SLOT_FETCH_HI);
                    if (!dma_rw) begin
                        oe_s = 1'b1;
                        we_s = (slot_s != SLOT_FETCH_HI);
                    end else begin
                        oe_s = 1'b0;
                        we_s = 1'b1;
                    end
`else
                    oe_s = 1'b0;
`endif
                end
            end
            SLOT_CPU_A, SLOT_CPU_B: begin
                if (cpu_addr_hi == VIA_PAGE) begin
                    via_s = 1'b0;
                end else if (cpu_addr_hi[7:6] == ROM_DECODE) begin
                    rom_s = 1'b0;
                end else begin
                    ram_s = 1'b0;
                end
                oe_s = ~cpu_rw;
                we_s = ~((slot_s == SLOT_CPU_B) && !cpu_rw);
            end
            default: begin
                latch_s = 1'b1;
            end
        endcase
    end

    // Output registers; reset forces every strobe inactive and aborts DMA
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            latch_r  <= 1'b1;
            ram_r    <= 1'b1;
            rom_r    <= 1'b1;
            via_r    <= 1'b1;
            oe_r     <= 1'b1;
            we_r     <= 1'b1;
            vid_en_r <= 1'b0;
            grant_r  <= 1'b0;
            ack_r    <= 1'b0;
        end else begin
            latch_r  <= latch_s;
            ram_r    <= ram_s;
            rom_r    <= rom_s;
            via_r    <= via_s;
            oe_r     <= oe_s;
            we_r     <= we_s;
            vid_en_r <= vid_en_s && is_fetch_slot(slot_s);
            grant_r  <= grant_s;
            ack_r    <= ack_s;
        end
    end

    assign latch     = latch_r;
    assign ram       = ram_r;
    assign rom       = rom_r;
    assign via       = via_r;
    assign oe        = oe_r;
    assign we        = we_r;
    assign vid_en    = vid_en_r;
    assign dma_grant = grant_r;
    assign dma_ack   = ack_r;

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler. pslot tracks the slot currently
// presented on the outputs; it is 0 in the first clock after reset release.
module tb_bus_scheduler;

    logic       master_clock = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_addr_hi;
    logic       cpu_rw, blank, line_start, dma_req, dma_rw;
    logic       phi2, last, latch, ram, rom, via, oe, we, vid_en, dma_grant, dma_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int pslot = 0;
    int ack_seen = 0;
    int cnt_m;

    typedef struct {
        logic [7:0] addr;
        logic       rw;
        logic [5:0] exp2;   // {latch,ram,rom,via,oe,we} in slot 2
        logic [5:0] exp3;   // same in slot 3
    } vec_t;

    vec_t vecs [9];

    localparam logic [5:0] VID_S0 = 6'b001101;
    localparam logic [5:0] VID_S1 = 6'b101101;

    always #5 master_clock = ~master_clock;

    bus_scheduler #(.VIA_PAGE(8'h07), .DMA_LINE_MAX(16)) dut (
        .master_clock (master_clock), .reset_n (reset_n),
        .cpu_addr_hi  (cpu_addr_hi),  .cpu_rw  (cpu_rw),
        .blank        (blank),        .line_start (line_start),
        .dma_req      (dma_req),      .dma_rw  (dma_rw),
        .phi2 (phi2), .last (last), .latch (latch), .ram (ram), .rom (rom),
        .via (via), .oe (oe), .we (we), .vid_en (vid_en),
        .dma_grant (dma_grant), .dma_ack (dma_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (slot %0d, t=%0t)", name, act, exp, pslot, $time);
        end
    endtask

    task automatic tick();
        @(posedge master_clock);
        #1;
        pslot = (pslot + 1) % 4;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 4; i++) begin
            if (pslot != s) tick();
        end
    endtask

    function automatic logic [5:0] strobes();
        return {latch, ram, rom, via, oe, we};
    endfunction

    // Model-checked DMA run: pairs are DMA while the model count is below 16
    task automatic dma_run(input int cnt_in, input int steps, output int cnt_out);
        int   cnt;
        logic exp_dma;
        cnt = cnt_in;
        for (int i = 0; i < steps; i++) begin
            tick();
            exp_dma = (pslot < 2) && (cnt < 16);
            check("dma_grant", dma_grant, exp_dma);
            check("vid_en", vid_en, (pslot < 2) && !exp_dma);
            check("dma_ack", dma_ack, exp_dma && (pslot == 1));
            if (dma_ack) ack_seen++;
            if (exp_dma && (pslot == 1)) cnt++;
        end
        cnt_out = cnt;
    endtask

    initial begin
        vecs[0] = '{8'h07, 1'b0, 6'b111011, 6'b111010};
        vecs[1] = '{8'h07, 1'b1, 6'b111001, 6'b111001};
        vecs[2] = '{8'hC0, 1'b1, 6'b110101, 6'b110101};
        vecs[3] = '{8'hFF, 1'b0, 6'b110111, 6'b110110};
        vecs[4] = '{8'h12, 1'b1, 6'b101101, 6'b101101};
        vecs[5] = '{8'h3F, 1'b0, 6'b101111, 6'b101110};
        vecs[6] = '{8'h80, 1'b1, 6'b101101, 6'b101101};
        vecs[7] = '{8'h08, 1'b0, 6'b101111, 6'b101110};
        vecs[8] = '{8'h06, 1'b1, 6'b101101, 6'b101101};

        reset_n = 1'b0; cpu_addr_hi = 8'h07; cpu_rw = 1'b0;
        blank = 1'b1; dma_req = 1'b1; dma_rw = 1'b0; line_start = 1'b0;

        // Reset: three clocks with every output inactive
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_phi2", phi2, 1'b0);
            check("rst_last", last, 1'b0);
            check("rst_vid_en", vid_en, 1'b0);
            check("rst_grant", dma_grant, 1'b0);
            check("rst_ack", dma_ack, 1'b0);
            check("rst_strobes", strobes(), 6'h3F);
        end
        reset_n = 1'b1; blank = 1'b0; dma_req = 1'b0; pslot = 3;

        // phi2 follows 0,0,1,1 and last marks every fourth clock
        for (int i = 0; i < 12; i++) begin
            tick();
            check("phi2", phi2, pslot >= 2);
            check("last", last, pslot == 3);
        end

        // CPU slot decode vectors, plus the video fetch pair that follows
        for (int v = 0; v < 9; v++) begin
            wait_slot(1);
            cpu_addr_hi = vecs[v].addr;
            cpu_rw      = vecs[v].rw;
            tick();
            check("cpu_slot2", strobes(), vecs[v].exp2);
            check("cpu_slot2_en", {vid_en, dma_grant}, 2'b00);
            tick();
            check("cpu_slot3", strobes(), vecs[v].exp3);
            tick();
            check("vid_slot0", strobes(), VID_S0);
            check("vid_slot0_en", {vid_en, dma_grant}, 2'b10);
            tick();
            check("vid_slot1", strobes(), VID_S1);
        end

        // Visible area: DMA request is never granted
        cpu_addr_hi = 8'h12; cpu_rw = 1'b1;
        blank = 1'b0; dma_req = 1'b1; dma_rw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("vis_grant", dma_grant, 1'b0);
            check("vis_vid_en", vid_en, pslot < 2);
        end

`ifdef DMA_PORT_EN
        // Blanking: exactly 16 DMA pairs, then video until the next line
        wait_slot(1);
        blank = 1'b1; dma_req = 1'b1; dma_rw = 1'b1;
        ack_seen = 0;
        dma_run(0, 120, cnt_m);
        check("acks_per_line", ack_seen, 16);

        // Line start after saturation: DMA on the next wrap
        wait_slot(0);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        ack_seen = 0;
        dma_run(0, 20, cnt_m);
        check("acks_after_line", ack_seen, 5);

        // Line start together with an ack leaves the count at 1
        check("ack_before_ls", dma_ack, 1'b1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        ack_seen = 0;
        dma_run(1, 100, cnt_m);
        check("acks_after_coincident", ack_seen, 15);

        // dma_req dropped inside a DMA pair: pair completes, then video
        wait_slot(0);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick(); tick(); tick();
        check("drop_grant", dma_grant, 1'b1);
        check("dma_rd_s0", strobes(), 6'b101101);
        dma_req = 1'b0;
        tick();
        check("drop_ack", dma_ack, 1'b1);
        check("dma_rd_s1", strobes(), 6'b101101);
        tick(); tick(); tick();
        check("drop_next_vid", {vid_en, dma_grant}, 2'b10);
        tick();
        check("drop_next_ack", dma_ack, 1'b0);

        // blank falls inside a DMA write pair: pair completes, then video
        dma_req = 1'b1; dma_rw = 1'b0;
        tick(); tick(); tick();
        check("wr_grant", dma_grant, 1'b1);
        check("dma_wr_s0", strobes(), 6'b101111);
        blank = 1'b0;
        tick();
        check("wr_ack", dma_ack, 1'b1);
        check("dma_wr_s1", strobes(), 6'b101110);
        tick(); tick(); tick();
        check("blank_next_vid", {vid_en, dma_grant}, 2'b10);

        // Reset in slot 0 of a DMA pair: no ack, video after release
        blank = 1'b1; dma_rw = 1'b1;
        tick(); tick(); tick(); tick();
        check("pre_rst_grant", dma_grant, 1'b1);
`else
        // DMA port absent: requests during blanking are ignored
        wait_slot(1);
        blank = 1'b1; dma_req = 1'b1; dma_rw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            line_start = (i % 13 == 5);
            tick();
            check("nodma_grant", dma_grant, 1'b0);
            check("nodma_ack", dma_ack, 1'b0);
            check("nodma_vid_en", vid_en, pslot < 2);
            if (pslot == 1) check("nodma_slot1", strobes(), VID_S1);
        end
        line_start = 1'b0;
        wait_slot(0);
`endif
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_ack", dma_ack, 1'b0);
            check("rst_mid_grant", dma_grant, 1'b0);
            check("rst_mid_strobes", strobes(), 6'h3F);
        end
        reset_n = 1'b1; pslot = 3;
        tick();
        check("rel_s0_en", {vid_en, dma_grant}, 2'b10);
        check("rel_s0_strobes", strobes(), VID_S0);
        tick();
        check("rel_s1_ack", dma_ack, 1'b0);
        check("rel_s1_vid_en", vid_en, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 The block SHALL have parameter VIA_PAGE, default 8'h07; address-high value that selects the VIA.
REQ-002 The block SHALL have parameter DMA_LINE_MAX, default 16; the maximum number of DMA grants per scanline.
REQ-003 The block SHALL have port master_clock, input, width 1; the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, width 1; synchronous, active-low reset.
REQ-005 The block SHALL have port cpu_addr_hi, input, width 8; CPU address bits 15:8.
REQ-006 The block SHALL have port cpu_rw, input, width 1; 1 = CPU read, 0 = CPU write.
REQ-007 The block SHALL have port blank, input, width 1; 1 while the video timing is outside the visible area.
REQ-008 The block SHALL have port line_start, input, width 1; one-clock pulse at the start of each scanline.
REQ-009 The block SHALL have port dma_req, input, width 1; DMA requester request, level-held.
REQ-010 The block SHALL have port dma_rw, input, width 1; DMA direction, 1 = read.
REQ-011 The block SHALL have outputs phi2, last, latch, ram, rom, via, oe and we, each 1 bit; the CPU clock, final-quarter flag and the active-low strobes.
REQ-012 The block SHALL have outputs vid_en and dma_grant, each 1 bit; bus-owner enables for the video-fetch slots.
REQ-013 The block SHALL have output dma_ack, 1 bit; one-clock completion pulse.

Function
REQ-014 A 2-bit slot counter SHALL advance by 1 every clock and wrap 3->0. The slots are: 0 = fetch-lo, 1 = fetch-hi, 2 = cpu-A, 3 = cpu-B.
REQ-015 phi2 SHALL be slot[1], last SHALL be 1 only in slot 3, and both SHALL be registered.
REQ-016 The owner FSM SHALL have states VIDEO and DMA, and SHALL transition only on the slot 3->0 edge.
REQ-017 On the slot 3->0 edge, the next owner SHALL be DMA if dma_req=1, blank=1, and the line count is below DMA_LINE_MAX; otherwise it SHALL be VIDEO.
REQ-018 In slots 0-1, vid_en SHALL equal (owner==VIDEO) and dma_grant SHALL equal (owner==DMA). Both SHALL be 0 in slots 2-3.
REQ-019 dma_ack SHALL pulse for one clock in slot 1 when owner==DMA.
REQ-020 The 6-bit per-line counter SHALL increment on each dma_ack and saturate at DMA_LINE_MAX.
REQ-021 When line_start and dma_ack occur in the same clock, the per-line counter SHALL become 1.
REQ-022 In slots 0-1, latch SHALL be 0 only in slot 0 with owner==VIDEO, ram SHALL be 0, rom and via SHALL be 1, and oe SHALL be 0.
REQ-023 For a DMA write, we SHALL be 0 in slot 1 and oe SHALL be 1 in slots 0-1.
REQ-024 In slots 2-3, via SHALL be 0 if cpu_addr_hi==VIA_PAGE, rom SHALL be 0 if cpu_addr_hi[7:6]==2'b11, and ram SHALL be 0 otherwise.
REQ-025 In slots 2-3, oe SHALL be 0 if cpu_rw=1, and we SHALL be 0 only in slot 3 with cpu_rw=0.
REQ-026 If dma_req drops while owner==DMA, the current slot pair SHALL complete, dma_ack SHALL still pulse, and the next owner SHALL be VIDEO.
REQ-027 If blank falls while owner==DMA, the pair SHALL complete and the next pair SHALL be VIDEO.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL set slot=0, owner=VIDEO and the line counter to 0.
REQ-029 While reset_n=0, phi2, last, vid_en, dma_grant and dma_ack SHALL be 0.
REQ-030 While reset_n=0, latch, ram, rom, via, oe and we SHALL all be 1.
REQ-031 A reset during DMA ownership SHALL abort the transfer and SHALL NOT produce dma_ack.
REQ-032 After reset_n rises, slot 0 SHALL occur in the first clock.

Configuration
REQ-033 When DMA_PORT_EN is defined, the DMA owner, counter and handshake SHALL be as specified above.
REQ-034 When DMA_PORT_EN is undefined, dma_req and dma_rw SHALL be ignored, dma_grant and dma_ack SHALL be tied to 0, and the owner SHALL always be VIDEO.

Structure
REQ-035 The shared package bus_pkg SHALL hold the slot encodings, the owner enum {VIDEO, DMA}, and the ROM decode constant 2'b11.
REQ-036 The slot counter, phi2 and last SHALL reside in sub-module bus_slot_counter.
REQ-037 The owner FSM, line counter and strobe decode SHALL reside in bus_scheduler.

Verification
REQ-038 The bench SHALL check: reset_n=0 for 3 clocks then 1 -> phi2 follows 0,0,1,1 repeating, last=1 every 4th clock, all strobes high during reset.
REQ-039 The bench SHALL check: blank=0, dma_req=1 for 40 clocks -> dma_grant never 1, vid_en=1 in every slot 0-1.
REQ-040 The bench SHALL check: blank=1, dma_req=1, DMA_LINE_MAX=16 -> exactly 16 dma_ack pulses, then VIDEO until line_start.
REQ-041 The bench SHALL check: line_start after saturation -> DMA resumes on the next slot 3->0 edge.
REQ-042 The bench SHALL check: cpu_addr_hi=8'h07 with cpu_rw=0 -> via=0 in slots 2-3, we=0 in slot 3 only, ram=1.
REQ-043 The bench SHALL check: cpu_addr_hi=8'hC0 -> rom=0 in slots 2-3.
REQ-044 The bench SHALL check: reset_n=0 asserted in slot 0 of a DMA pair -> no dma_ack, owner=VIDEO after release.
REQ-045 The bench SHALL check: DMA_PORT_EN undefined, dma_req=1, blank=1 -> dma_grant=0 and dma_ack=0 throughout.
